// File: rtl/router_egress_port.sv
// Egress side of one router output FIFO: pops header/payload/parity bytes and forwards them
// on a valid/ready stream with SOP/EOP framing, parity checking and a stall timeout.
module router_egress_port #(
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       fifo_soft_reset,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_sop,
  output logic       m_eop,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       pkt_abort,
  output logic       busy,
  output logic [1:0] state_o
);

  // Handshake: a byte moves when m_valid & m_ready in the same cycle; while m_valid=1 and
  // m_ready=0 the byte and its sop/eop flags hold stable until accepted or the port aborts.

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DRAIN} state_e;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  state_e          state_q;
  beat_t [1:0]     buf_q, buf_d;
  logic [1:0]      occ_q, occ_d;
  logic            inflight_q;
  logic [6:0]      req_left_q;
  logic [7:0]      acc_q;
  logic            err_q;
  logic [TW-1:0]   tmo_q;
  logic            pkt_done_q, parity_err_q, pkt_abort_q;

  logic            pop, push, stall, timeout, last_push, read_permit, room;
  logic [2:0]      fill;
  beat_t           new_beat;

  assign m_valid   = (occ_q != 2'd0);
  assign pop       = m_valid & m_ready;
  assign stall     = m_valid & ~m_ready;
  assign push      = inflight_q;
  assign timeout   = resetn & stall & (tmo_q == TMO_LAST);
  // The parity byte is the one whose read took req_left from 1 to 0.
  assign last_push = push & (state_q == S_BODY) & (req_left_q == 7'd0);

  assign read_permit = (state_q == S_IDLE) | ((state_q == S_BODY) & (req_left_q != 7'd0));
  assign fill        = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign room        = (fill < 3'd2);
  assign fifo_rd_en  = resetn & ~fifo_empty & read_permit & room & ~timeout;

  assign fifo_soft_reset = timeout;
  assign m_data     = buf_q[0].data;
  assign m_sop      = buf_q[0].sop;
  assign m_eop      = buf_q[0].eop;
  assign pkt_done   = pkt_done_q;
  assign parity_err = parity_err_q;
  assign pkt_abort  = pkt_abort_q;
  assign busy       = (state_q != S_IDLE);
  assign state_o    = state_q;

  assign new_beat = '{sop: (state_q == S_HDR), eop: last_push, data: fifo_dout};

  always_comb begin
    buf_d = buf_q;
    occ_d = occ_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      occ_d    = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) buf_d[0] = new_beat;
      else               buf_d[1] = new_beat;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      buf_q        <= '0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      req_left_q   <= 7'd0;
      acc_q        <= 8'h00;
      err_q        <= 1'b0;
      tmo_q        <= '0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      pkt_abort_q  <= 1'b0;
    end else begin
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      pkt_abort_q  <= timeout;
      if (timeout) begin
        // Drop everything for the stalled packet; the FIFO is cleared by the same pulse.
        state_q    <= S_IDLE;
        buf_q      <= '0;
        occ_q      <= 2'd0;
        inflight_q <= 1'b0;
        req_left_q <= 7'd0;
        acc_q      <= 8'h00;
        err_q      <= 1'b0;
        tmo_q      <= '0;
      end else begin
        buf_q      <= buf_d;
        occ_q      <= occ_d;
        inflight_q <= fifo_rd_en;
        tmo_q      <= stall ? tmo_q + TW'(1) : '0;
        if (fifo_rd_en && state_q == S_BODY) req_left_q <= req_left_q - 7'd1;
        case (state_q)
          S_IDLE: if (fifo_rd_en) state_q <= S_HDR;
          S_HDR: if (push) begin
            req_left_q <= {1'b0, fifo_dout[7:2]} + 7'd1;
            acc_q      <= fifo_dout;
            err_q      <= 1'b0;
            state_q    <= S_BODY;
          end
          S_BODY: if (push) begin
            if (last_push) begin
              err_q   <= (fifo_dout != acc_q);
              state_q <= S_DRAIN;
            end else begin
              acc_q <= acc_q ^ fifo_dout;
            end
          end
          S_DRAIN: if (pop && buf_q[0].eop) begin
            state_q      <= S_IDLE;
            pkt_done_q   <= 1'b1;
            parity_err_q <= err_q;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_egress_port.sv
// Randomized bench for router_egress_port: a FIFO model feeds packets, a packet-level scoreboard
// checks the egress stream, framing, pulses, stall hold, timeout and reset behaviour.
module tb_router_egress_port;
  localparam int TMO = 30;

  logic       clk = 1'b0;
  logic       resetn, fifo_empty, fifo_rd_en, fifo_soft_reset;
  logic [7:0] fifo_dout, m_data;
  logic       m_valid, m_ready, m_sop, m_eop, pkt_done, parity_err, pkt_abort, busy;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  router_egress_port #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .fifo_soft_reset(fifo_soft_reset), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
    .pkt_done(pkt_done), .parity_err(parity_err), .pkt_abort(pkt_abort),
    .busy(busy), .state_o(state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] fifo_q[$];
  logic [9:0] exp_q[$];
  bit         exp_err_q[$];
  logic [7:0] pkt_b[$];

  int  ready_pct = 100;
  bit  gate_en   = 1'b0;
  bit  rd_pend   = 1'b0;
  bit  prev_eop_hs = 1'b0, prev_err = 1'b0, prev_soft = 1'b0, prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;
  int  stall_run = 0, outstanding = 0, rd_left = 0, t_hdr_rd = 0;
  int  beats = 0, done_cnt = 0, abort_cnt = 0, err_cnt = 0;
  bit  pkt_open = 1'b0, sop_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue the bytes in pkt_b as one packet and derive its expected beats and parity verdict.
  task automatic commit_pkt();
    logic [7:0] h, x;
    logic       s, e;
    int         len;
    h   = pkt_b[0];
    len = int'(h[7:2]);
    x   = 8'h00;
    for (int i = 0; i <= len; i++) x = x ^ pkt_b[i];
    for (int i = 0; i < len + 2; i++) begin
      s = (i == 0);
      e = (i == len + 1);
      fifo_q.push_back(pkt_b[i]);
      exp_q.push_back({s, e, pkt_b[i]});
    end
    exp_err_q.push_back(pkt_b[len+1] != x);
  endtask

  task automatic rand_pkt(input int len, input bit bad);
    logic [7:0] b, x;
    logic [5:0] l6;
    pkt_b.delete();
    l6 = len[5:0];
    b  = {l6, 2'($urandom_range(3))};
    x  = b;
    pkt_b.push_back(b);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(255));
      x = x ^ b;
      pkt_b.push_back(b);
    end
    pkt_b.push_back(bad ? ~x : x);
    commit_pkt();
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    exp_err_q.delete();
    outstanding = 0;
    rd_left     = 0;
    pkt_open    = 1'b0;
    sop_seen    = 1'b1;
    rd_pend     = 1'b0;
  endtask

  // Runs at the falling edge: every DUT output is compared against the model here.
  task automatic sample_cycle();
    logic       hs, stall, new_eop, new_err;
    logic [9:0] beat, expb;
    logic [7:0] h;
    hs    = m_valid & m_ready;
    stall = m_valid & ~m_ready;
    beat  = {m_sop, m_eop, m_data};
    rd_pend = 1'b0;
    if (!resetn) begin
      clear_model();
      prev_eop_hs = 1'b0; prev_err = 1'b0; prev_soft = 1'b0; prev_stall = 1'b0;
      stall_run = 0;
      return;
    end
    check("pkt_done", pkt_done, prev_eop_hs);
    check("parity_err", parity_err, prev_eop_hs & prev_err);
    check("pkt_abort", pkt_abort, prev_soft);
    if (prev_soft) begin
      check("abort_valid", m_valid, 0);
      check("abort_busy", busy, 0);
    end
    if (prev_stall && !prev_soft) begin
      check("hold_valid", m_valid, 1);
      check("hold_beat", beat, prev_beat);
    end
    stall_run = stall ? stall_run + 1 : 0;
    check("soft_reset", fifo_soft_reset, (stall_run == TMO));
    if (pkt_done) done_cnt++;
    if (pkt_abort) abort_cnt++;
    if (parity_err) err_cnt++;
    if (m_valid && m_sop && !sop_seen) begin
      check("hdr_latency", cyc - t_hdr_rd, 2);
      sop_seen = 1'b1;
    end
    new_eop = 1'b0;
    new_err = 1'b0;
    if (hs) begin
      expb = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
      check("beat", beat, expb);
      beats++;
      outstanding--;
      if (expb[8]) begin
        pkt_open = 1'b0;
        new_eop  = 1'b1;
        new_err  = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'b0;
      end
    end
    if (fifo_rd_en) begin
      check("rd_when_empty", fifo_empty, 0);
      outstanding++;
      check("skid_fill_le2", (outstanding <= 2), 1);
      if (rd_left == 0) begin
        check("rd_boundary", pkt_open, 0);
        pkt_open = 1'b1;
        h        = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        rd_left  = int'(h[7:2]) + 1;
        t_hdr_rd = cyc;
        sop_seen = 1'b0;
      end else begin
        rd_left--;
      end
      rd_pend = 1'b1;
    end
    if (fifo_soft_reset) clear_model();
    prev_eop_hs = new_eop;
    prev_err    = new_err;
    prev_soft   = fifo_soft_reset;
    prev_stall  = stall;
    prev_beat   = beat;
  endtask

  task automatic drive_inputs();
    if (rd_pend && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    m_ready    = (int'($urandom_range(99)) < ready_pct);
    fifo_empty = (fifo_q.size() == 0) || (gate_en && ($urandom_range(3) == 0));
  endtask

  task automatic step();
    @(negedge clk);
    sample_cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive_inputs();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || fifo_q.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", (n < budget), 1);
    repeat (2) step();
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin
      step();
      n++;
    end
    check("beats_in_budget", (n < budget), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_soft"}, fifo_soft_reset, 0);
    check({tag, "_data"}, m_data, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_sop"}, m_sop, 0);
    check({tag, "_eop"}, m_eop, 0);
    check({tag, "_done"}, pkt_done, 0);
    check({tag, "_perr"}, parity_err, 0);
    check({tag, "_abort"}, pkt_abort, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, state_o, 0);
  endtask

  initial begin
    int d0, b0, e0, a0;
    resetn = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
    repeat (3) step();
    check_outputs_zero("reset");
    resetn = 1'b1;

    // Known good packet, then the same packet with a corrupted parity byte.
    ready_pct = 100;
    pkt_b = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    d0 = done_cnt; b0 = beats; e0 = err_cnt;
    commit_pkt();
    drain(200);
    check("t1_done", done_cnt - d0, 1);
    check("t1_beats", beats - b0, 5);
    check("t1_perr", err_cnt - e0, 0);

    pkt_b = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    d0 = done_cnt; b0 = beats; e0 = err_cnt;
    commit_pkt();
    drain(200);
    check("t2_done", done_cnt - d0, 1);
    check("t2_beats", beats - b0, 5);
    check("t2_perr", err_cnt - e0, 1);

    // Mid-payload backpressure.
    b0 = beats; d0 = done_cnt;
    rand_pkt(8, 1'b0);
    wait_beats(b0 + 3, 50);
    ready_pct = 0;
    repeat (5) step();
    ready_pct = 100;
    drain(200);
    check("t3_beats", beats - b0, 10);
    check("t3_done", done_cnt - d0, 1);

    // Stall long enough to abort.
    b0 = beats; a0 = abort_cnt; d0 = done_cnt;
    rand_pkt(20, 1'b0);
    wait_beats(b0 + 2, 50);
    ready_pct = 0;
    repeat (TMO + 6) step();
    check("t4_abort", abort_cnt - a0, 1);
    check("t4_busy", busy, 0);
    check("t4_valid", m_valid, 0);
    ready_pct = 100;
    drain(100);
    check("t4_no_done", done_cnt - d0, 0);

    // Back-to-back packets with a flaky empty flag.
    gate_en = 1'b1; ready_pct = 70;
    d0 = done_cnt;
    rand_pkt(0, 1'b0);
    rand_pkt(2, 1'b0);
    drain(400);
    check("t5_done", done_cnt - d0, 2);
    gate_en = 1'b0; ready_pct = 100;

    // Reset in the middle of a payload, then a clean packet.
    b0 = beats;
    rand_pkt(5, 1'b0);
    wait_beats(b0 + 2, 50);
    resetn = 1'b0;
    step();
    check_outputs_zero("t6");
    resetn = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    rand_pkt(4, 1'b1);
    drain(200);
    check("t6_done", done_cnt - d0, 1);
    check("t6_perr", err_cnt - e0, 1);

    // Randomized traffic.
    for (int p = 0; p < 12; p++) begin
      ready_pct = int'($urandom_range(100, 60));
      gate_en   = 1'($urandom_range(1));
      d0 = done_cnt;
      a0 = abort_cnt;
      for (int k = 0; k < 3; k++) rand_pkt(int'($urandom_range(20)), ($urandom_range(3) == 0));
      drain(2000);
      if (abort_cnt == a0) check("rand_done", done_cnt - d0, 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
